lsu_resp: RTL and testbench

Load/store responder for the single-cycle RISC-V core. Accepts the memory request produced by the decoded `mem_write`/`mem_op` control fields, performs one 32-bit word-bus transaction, and returns load data already sign- or zero-extended for register write-back. Sits between the core datapath and the data-memory bus. Store acknowledgements return through the same response path.

---
 rtl/lsu_resp_if.sv | 36 +++
 rtl/lsu_resp.sv | 183 ++++++++++++++++++
 tb/tb_lsu_resp.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_resp_if.sv
// Core-request / data-bus bundle for lsu_resp. slave = responder view, master = core + memory view.
interface lsu_resp_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_write, req_op, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_write, req_op, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/lsu_resp.sv
// Load/store responder: one word-bus transaction per core request, extended load data back.
// Optional LSU_MISALIGN_CHECK_EN turns misaligned halfword/word accesses into errors.
module lsu_resp #(
  parameter int unsigned ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  lsu_resp_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic [1:0]        req_off;
  logic              op_legal;
  logic              misalign;
  logic              req_ok;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic [31:0]       ld_shift;
  logic [31:0]       ld_data;

  assign bus.req_ready = (state_q == StIdle) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_off       = bus.req_addr[1:0];
  assign req_ok        = op_legal && !misalign;

  always_comb begin
    op_legal = 1'b0;
    case (bus.req_op)
      3'b000, 3'b001, 3'b010: op_legal = 1'b1;
      3'b100, 3'b101:         op_legal = !bus.req_write;
      default:                op_legal = 1'b0;
    endcase
    misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = ((bus.req_op[1:0] == 2'b01) && req_off[0]) ||
               ((bus.req_op[1:0] == 2'b10) && (req_off != 2'b00));
`endif
  end

  // Strobes shift within a 4-bit vector, so lanes past byte 3 fall off.
  always_comb begin
    st_wdata = bus.req_wdata;
    st_wstrb = 4'b1111 << req_off;
    case (bus.req_op[1:0])
      2'b00: begin
        st_wdata = {4{bus.req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_off;
      end
      2'b01: begin
        st_wdata = {2{bus.req_wdata[15:0]}};
        st_wstrb = 4'b0011 << req_off;
      end
      default: ;
    endcase
    if (!bus.req_write) st_wstrb = 4'b0000;
  end

  always_comb begin
    ld_shift = bus.mem_rdata >> {off_q, 3'b000};
    case (op_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      3'b010:  ld_data = ld_shift;
      default: ld_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = req_ok ? StReq : StResp;
      StReq:   if (bus.mem_gnt) state_d = StWait;
      StWait:  if (bus.mem_rvalid) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    write_d     = write_q;
    op_d        = op_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          write_d = bus.req_write;
          op_d    = bus.req_op;
          off_d   = req_off;
          if (req_ok) begin
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_write;
            mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_wstrb_d = st_wstrb;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end
        end
      end
      StReq: if (bus.mem_gnt) mem_req_d = 1'b0;
      StWait: begin
        if (bus.mem_rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = write_q ? 32'd0 : ld_data;
        end
      end
      StResp: begin
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      op_q        <= op_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_resp.sv
// Directed bench for lsu_resp: vector table of single transactions plus hand-built
// sequences for completion-with-grant and reset-in-WAIT.
module tb_lsu_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lsu_resp_if #(.ADDR_W(32)) bus ();

  lsu_resp #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        write;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    logic        use_bus;
    logic [3:0]  wstrb;
    logic [31:0] mwdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic write, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int stall, input logic use_bus,
                         input logic [3:0] wstrb, input logic [31:0] mwdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.write = write; v.op = op; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.stall = stall; v.use_bus = use_bus; v.wstrb = wstrb;
    v.mwdata = mwdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".mem_req"}, 64'(bus.mem_req), 64'd0);
    check({name, ".mem_we"}, 64'(bus.mem_we), 64'd0);
    check({name, ".mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check({name, ".mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({name, ".mem_wstrb"}, 64'(bus.mem_wstrb), 64'd0);
    check({name, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({name, ".rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    check({name, ".rsp_err"}, 64'(bus.rsp_err), 64'd0);
  endtask

  // Entered and left at posedge+#1.
  task automatic issue(input logic write, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = write;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    check({v.name, ".ready_pre"}, 64'(bus.req_ready), 64'd1);
    issue(v.write, v.op, v.addr, v.wdata);
    check({v.name, ".ready_n1"}, 64'(bus.req_ready), 64'd0);
    if (v.use_bus) begin
      check({v.name, ".we"}, 64'(bus.mem_we), 64'(v.write));
      check({v.name, ".wstrb"}, 64'(bus.mem_wstrb), 64'(v.wstrb));
      if (v.write) check({v.name, ".wdata"}, 64'(bus.mem_wdata), 64'(v.mwdata));
      for (int k = 0; k <= v.stall; k++) begin
        check({v.name, ".mem_req"}, 64'(bus.mem_req), 64'd1);
        check({v.name, ".addr"}, 64'(bus.mem_addr), 64'(v.addr & 32'hFFFF_FFFC));
        check({v.name, ".ready_req"}, 64'(bus.req_ready), 64'd0);
        if (k == v.stall) bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
      end
      check({v.name, ".mem_req_wait"}, 64'(bus.mem_req), 64'd0);
      check({v.name, ".rsp_early"}, 64'(bus.rsp_valid), 64'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = v.rdata;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'd0;
    end else begin
      check({v.name, ".no_bus"}, 64'(bus.mem_req), 64'd0);
    end
    check({v.name, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    check({v.name, ".rsp_err"}, 64'(bus.rsp_err), 64'(v.exp_err));
    check({v.name, ".rsp_rdata"}, 64'(bus.rsp_rdata), 64'(v.exp_rdata));
    check({v.name, ".ready_resp"}, 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    check({v.name, ".rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
    check({v.name, ".ready_post"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_op = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;

    add_vec("lb_1003",  1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 0, 1'b1, 4'b0000, 32'h0,
            32'hFFFFFF80, 1'b0);
    add_vec("lbu_1003", 1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF1234, 0, 1'b1, 4'b0000, 32'h0,
            32'h00000080, 1'b0);
    add_vec("lh_1002",  1'b0, 3'b001, 32'h1002, 32'h0, 32'h80FF1234, 0, 1'b1, 4'b0000, 32'h0,
            32'hFFFF80FF, 1'b0);
    add_vec("lhu_1002", 1'b0, 3'b101, 32'h1002, 32'h0, 32'h80FF1234, 0, 1'b1, 4'b0000, 32'h0,
            32'h000080FF, 1'b0);
    add_vec("lb_1001",  1'b0, 3'b000, 32'h1001, 32'h0, 32'h80FF1234, 1, 1'b1, 4'b0000, 32'h0,
            32'h00000012, 1'b0);
    add_vec("lh_1000",  1'b0, 3'b001, 32'h1000, 32'h0, 32'h80FF1234, 0, 1'b1, 4'b0000, 32'h0,
            32'h00001234, 1'b0);
    add_vec("sb_1001",  1'b1, 3'b000, 32'h1001, 32'h123456AB, 32'hFFFFFFFF, 0, 1'b1, 4'b0010,
            32'hABABABAB, 32'h0, 1'b0);
    add_vec("sb_1003",  1'b1, 3'b000, 32'h1003, 32'h00000055, 32'h0, 0, 1'b1, 4'b1000,
            32'h55555555, 32'h0, 1'b0);
    add_vec("sh_1002",  1'b1, 3'b001, 32'h1002, 32'hDEADBEEF, 32'h0, 0, 1'b1, 4'b1100,
            32'hBEEFBEEF, 32'h0, 1'b0);
    add_vec("sw_3000",  1'b1, 3'b010, 32'h3000, 32'hCAFEF00D, 32'h0, 0, 1'b1, 4'b1111,
            32'hCAFEF00D, 32'h0, 1'b0);
    add_vec("lw_2000",  1'b0, 3'b010, 32'h2000, 32'h0, 32'h13579BDF, 3, 1'b1, 4'b0000, 32'h0,
            32'h13579BDF, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    add_vec("lw_1002",  1'b0, 3'b010, 32'h1002, 32'h0, 32'h0, 0, 1'b0, 4'b0000, 32'h0,
            32'h0, 1'b1);
    add_vec("sh_1003",  1'b1, 3'b001, 32'h1003, 32'h0000BEEF, 32'h0, 0, 1'b0, 4'b0000, 32'h0,
            32'h0, 1'b1);
`else
    add_vec("lw_1002",  1'b0, 3'b010, 32'h1002, 32'h0, 32'h80FF1234, 0, 1'b1, 4'b0000, 32'h0,
            32'h000080FF, 1'b0);
    add_vec("sh_1003",  1'b1, 3'b001, 32'h1003, 32'h0000BEEF, 32'h0, 0, 1'b1, 4'b1000,
            32'hBEEFBEEF, 32'h0, 1'b0);
`endif
    add_vec("ld_op011", 1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 0, 1'b0, 4'b0000, 32'h0,
            32'h0, 1'b1);
    add_vec("ld_op110", 1'b0, 3'b110, 32'h1000, 32'h0, 32'h0, 0, 1'b0, 4'b0000, 32'h0,
            32'h0, 1'b1);
    add_vec("st_op100", 1'b1, 3'b100, 32'h1000, 32'h12345678, 32'h0, 0, 1'b0, 4'b0000, 32'h0,
            32'h0, 1'b1);
    add_vec("st_op101", 1'b1, 3'b101, 32'h1000, 32'h12345678, 32'h0, 0, 1'b0, 4'b0000, 32'h0,
            32'h0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("reset.ready", 64'(bus.req_ready), 64'd0);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset.ready_after", 64'(bus.req_ready), 64'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Completion coinciding with grant must not count.
    issue(1'b0, 3'b010, 32'h4000, 32'h0);
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD0000;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    check("gnt_rvalid.mem_req", 64'(bus.mem_req), 64'd0);
    @(posedge clk); #1;
    check("gnt_rvalid.no_rsp", 64'(bus.rsp_valid), 64'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h11223344;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    check("gnt_rvalid.rsp", 64'(bus.rsp_valid), 64'd1);
    check("gnt_rvalid.rdata", 64'(bus.rsp_rdata), 64'h11223344);
    @(posedge clk); #1;

    // Reset while waiting for completion abandons the load.
    issue(1'b0, 3'b010, 32'h5000, 32'h0);
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wait.ready_in_rst", 64'(bus.req_ready), 64'd0);
    check_all_zero("rst_wait.in_rst");
    rst = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    check("rst_wait.ready", 64'(bus.req_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check_all_zero("rst_wait.after");
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
